shift_right_unit: RTL and testbench
===================================

# shift_right_unit

Multi-cycle logical/arithmetic right shifter for the MIPS execute stage. It serves SRL, SRA, SRLV and SRAV, and is the right-direction counterpart of the fixed left-shift used on branch offsets. It accepts one operand and a shift amount over a valid/ready handshake, shifts STEP bits per clock, and holds the result until the consumer takes it.

## Interface
- WIDTH, 32: operand width.
- STEP, 1: maximum bits shifted per clock. Legal values are 1, 2, 4 and 8.
- SHAMT_W, $clog2(WIDTH): shift-amount width. Derived; do not override.

- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset; the block's only reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  operand (rt).
- in_shamt  input  SHAMT_W  shift amount: instruction shamt, or rs[4:0] for the variable forms.
- in_arith  input  1  0 = logical (SRL), 1 = arithmetic (SRA).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Internal state: data_q, remaining_q (SHAMT_W bits), fill_q.
- FSM states are IDLE, SHIFT and HOLD.
- IDLE:
  - in_ready = 1.
  - Acceptance is in_valid && in_ready at a rising edge.
  - On acceptance: data_q <= in_data, remaining_q <= in_shamt, fill_q <= in_arith & in_data[WIDTH-1].
  - Next state is HOLD if in_shamt == 0, otherwise SHIFT.
- SHIFT, each clock:
  - k = min(STEP, remaining_q).
  - data_q <= data_q >> k, with the top k bits set to fill_q.
  - remaining_q <= remaining_q - k.
  - When remaining_q - k == 0, go to HOLD.
- HOLD:
  - out_valid = 1; out_data = data_q, held stable.
  - On out_valid && out_ready, go to IDLE.
- in_ready is high only in IDLE. No new request is accepted in SHIFT or HOLD, including in the same cycle as the output handshake.
- in_ready and out_valid decode from the state register only. There is no combinational path from any input to any output.
- Arithmetic and width rules:
  - The fill bit is sampled once at acceptance.
  - SRA of a negative operand fills with 1s; SRL always fills with 0s.
  - shamt = WIDTH-1 is the maximum; no wrap is possible.
- Inputs are don't-care whenever in_ready = 0.

## Timing
- Reset values (forced while rst_n is low): state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, busy = 0. Inputs are ignored while rst_n is low.
- Call the acceptance edge A. out_valid rises after edge A + ceil(shamt/STEP).
  - shamt = 0: out_valid rises right after edge A.
  - STEP = 1, shamt = 31: out_valid rises after A+31.
- in_ready returns high after the edge at which the output handshake completes.
- Back-to-back throughput is one operation per ceil(shamt/STEP) + 2 clocks when out_ready is held high.
- Backpressure: if out_ready stays low, the block holds HOLD indefinitely with out_data stable.
- Reset asserted mid-SHIFT or mid-HOLD aborts the operation. out_valid drops immediately (asynchronously), and the result is discarded.

## Structure
- Package mips_shift_pkg holds:
  - the state enum {S_IDLE, S_SHIFT, S_HOLD};
  - the op constants SH_SRL = 1'b0 and SH_SRA = 1'b1;
  - the legal-STEP check function.
- Sub-module shift_right_step is combinational. It takes data, fill and amt (0..STEP) and returns data shifted right by amt with fill. It is instantiated once, inside SHIFT.
- The top level contains only the FSM, the counters and the handshake logic.

## Test plan
- Logical shift, STEP=1: 0xF0000000, shamt 4, arith 0 -> out_data 0x0F000000; out_valid rises after edge A+4.
- Arithmetic shift and maximum amount:
  - 0xF0000000, shamt 4, arith 1 -> 0xFF000000.
  - 0x80000000, shamt 31, arith 1 -> 0xFFFFFFFF.
  - 0x80000000, shamt 31, arith 0 -> 0x00000001.
- Zero shift: 0x12345678, shamt 0 -> 0x12345678 with out_valid right after A; busy high for exactly one cycle when out_ready = 1.
- Backpressure: hold out_ready = 0 for 10 cycles in HOLD while driving in_valid = 1 with new data.
  - out_data stays stable, in_ready stays 0, and the new request is not accepted.
  - After out_ready goes high: IDLE next cycle, then the pending request is accepted.
- STEP=4 build: 0x80000000, shamt 7, arith 1 -> 0xFF000000 after A+2 (steps of 4 then 3); shamt 8 -> A+2.
- Reset mid-SHIFT: pull rst_n low at A+2 of a shamt-20 shift.
  - out_valid stays 0 and out_data = 0.
  - After release, a fresh 0x00000100 shamt-8 SRL returns 0x00000001.

Source files
------------

// File: rtl/mips_shift_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mips_shift_pkg                                     |
// | Description : Shared types and helpers for the MIPS right-shift  |
// |               unit (state encoding, shift op codes, STEP check). |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package mips_shift_pkg;

  // Controller states of the multi-cycle shifter.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  // Shift flavour selected by in_arith.
  localparam logic SH_SRL = 1'b0;
  localparam logic SH_SRA = 1'b1;

  // Only power-of-two step sizes up to a byte are supported.
  function automatic bit step_is_legal(input int step);
    return (step == 1) || (step == 2) || (step == 4) || (step == 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_right_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : shift_right_step                                   |
// | Description : Combinational single-step right shifter. Shifts    |
// |               data right by amt (0..STEP), filling vacated MSBs. |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module shift_right_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic             fill,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill_mask;

  // Logical shift, then OR in ones over the vacated top bits when filling.
  always_comb begin
    shifted   = data >> amt;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    result    = fill ? (shifted | fill_mask) : shifted;
  end

endmodule
`default_nettype wire

// File: rtl/shift_right_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : shift_right_unit                                   |
// | Description : Multi-cycle SRL/SRA shifter for the execute stage. |
// |               Accepts an operand over valid/ready, shifts up to  |
// |               STEP bits per clock, holds result until taken.     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module shift_right_unit
  import mips_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  // An unsupported STEP degrades to one bit per clock rather than
  // producing a shifter with a mis-sized amount port.
  localparam int                 EFF_STEP = step_is_legal(STEP) ? STEP : 1;
  localparam int                 AMT_W    = $clog2(EFF_STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_SH  = SHAMT_W'(EFF_STEP);
  localparam logic [AMT_W-1:0]   STEP_AMT = AMT_W'(EFF_STEP);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SHAMT_W-1:0]   remaining_q, remaining_d;
  logic                 fill_q, fill_d;

  logic [AMT_W-1:0]     step_amt;
  logic [SHAMT_W-1:0]   rem_next;
  logic [WIDTH-1:0]     step_result;

  // State and datapath registers; reset clears everything so out_data reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      remaining_q <= '0;
      fill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      fill_q      <= fill_d;
    end
  end

  // This clock's shift amount is min(STEP, remaining) and what is left after it.
  always_comb begin
    step_amt = (remaining_q >= STEP_SH) ? STEP_AMT : remaining_q[AMT_W-1:0];
    rem_next = remaining_q - SHAMT_W'(step_amt);
  end

  shift_right_step #(
    .WIDTH (WIDTH),
    .STEP  (EFF_STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .data   (data_q),
    .fill   (fill_q),
    .amt    (step_amt),
    .result (step_result)
  );

  // Next-state logic: zero-amount requests skip straight to HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = (in_shamt == '0) ? S_HOLD : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rem_next == '0) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: capture on acceptance, shift while in SHIFT, else hold.
  always_comb begin
    data_d      = data_q;
    remaining_d = remaining_q;
    fill_d      = fill_q;
    if ((state_q == S_IDLE) && in_valid) begin
      data_d      = in_data;
      remaining_d = in_shamt;
      // Fill bit is frozen here so the sign survives the shifting of data_q.
      fill_d      = (in_arith == SH_SRA) & in_data[WIDTH-1];
    end else if (state_q == S_SHIFT) begin
      data_d      = step_result;
      remaining_d = rem_next;
    end
  end

  // Outputs decode from registered state only; no input-to-output path.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_HOLD);
    busy      = (state_q != S_IDLE);
    out_data  = (state_q == S_HOLD) ? data_q : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_right_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_shift_right_unit                                |
// | Description : Self-checking bench for shift_right_unit, STEP=1   |
// |               and STEP=4 instances driven from shared inputs.    |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_shift_right_unit;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_arith;
  logic              out_ready;
  logic [31:0]       in_data;
  logic [4:0]        in_shamt;
  logic [1:0]        rdy, ovld, bsy;
  logic [1:0][31:0]  odat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_right_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_shamt(in_shamt), .in_arith(in_arith),
    .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odat[0]), .busy(bsy[0])
  );

  shift_right_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_shamt(in_shamt), .in_arith(in_arith),
    .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odat[1]), .busy(bsy[1])
  );

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic ar);
    logic signed [31:0] s;
    s = d;
    if (ar) return s >>> sh;
    return d >> sh;
  endfunction

  // Reference model: an operation in flight, clocks until its result shows, and the result.
  logic [1:0]       m_act;
  int               m_left [2];
  logic [1:0][31:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act     <= '0;
      m_left[0] <= 0;
      m_left[1] <= 0;
      m_res     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          if (in_valid) begin
            m_act[i]  <= 1'b1;
            m_left[i] <= (int'(in_shamt) + step_of(i) - 1) / step_of(i);
            m_res[i]  <= ref_shift(in_data, int'(in_shamt), in_arith);
          end
        end else if (m_left[i] > 0) begin
          m_left[i] <= m_left[i] - 1;
        end else if (out_ready) begin
          m_act[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h exp %h", name, idx, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic ev;
      ev = m_act[i] && (m_left[i] == 0);
      check("in_ready",  i, 32'(rdy[i]),  32'(!m_act[i]));
      check("out_valid", i, 32'(ovld[i]), 32'(ev));
      check("busy",      i, 32'(bsy[i]),  32'(m_act[i]));
      check("out_data",  i, odat[i], ev ? m_res[i] : 32'h0);
    end
  endtask

  // Every wait in the stimulus goes through here so the model is checked each cycle.
  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (rdy == 2'b11) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_timeout", 0, 32'(ok), 32'd1);
  endtask

  // One directed operation with out_ready high: result, latency and busy length per instance.
  task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic ar,
                        input logic [31:0] e0, input int l0, input logic [31:0] e1, input int l1);
    int          first [2];
    int          nbusy [2];
    logic [31:0] got   [2];
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_arith = ar;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      first[i] = -1;
      nbusy[i] = 0;
      got[i]   = '0;
    end
    for (int n = 0; n < 40; n++) begin
      tick();
      if (n == 0) in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (ovld[i] && first[i] < 0) begin
          first[i] = n;
          got[i]   = odat[i];
        end
        if (bsy[i]) nbusy[i]++;
      end
    end
    check("op_data",    0, got[0],          e0);
    check("op_latency", 0, 32'(first[0]),   32'(l0));
    check("op_busylen", 0, 32'(nbusy[0]),   32'(l0 + 1));
    check("op_data",    1, got[1],          e1);
    check("op_latency", 1, 32'(first[1]),   32'(l1));
    check("op_busylen", 1, 32'(nbusy[1]),   32'(l1 + 1));
  endtask

  initial begin
    bit ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_in_ready",  0, 32'(rdy),  32'd3);
    check("reset_out_valid", 0, 32'(ovld), 32'd0);
    check("reset_busy",      0, 32'(bsy),  32'd0);
    check("reset_out_data",  0, odat[0],   32'h0);
    rst_n = 1'b1;

    // Directed cases with hand-computed results and latencies (STEP=1 / STEP=4).
    run_op(32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000, 4,  32'h0F00_0000, 1);
    run_op(32'hF000_0000, 5'd4,  1'b1, 32'hFF00_0000, 4,  32'hFF00_0000, 1);
    run_op(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 31, 32'hFFFF_FFFF, 8);
    run_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 31, 32'h0000_0001, 8);
    run_op(32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 0,  32'h1234_5678, 0);
    run_op(32'h8000_0000, 5'd7,  1'b1, 32'hFF00_0000, 7,  32'hFF00_0000, 2);
    run_op(32'h8000_0000, 5'd8,  1'b1, 32'hFF80_0000, 8,  32'hFF80_0000, 2);

    // Backpressure: result must stay put and a waiting request must not sneak in.
    out_ready = 1'b0;
    wait_idle();
    in_valid = 1'b1;
    in_data  = 32'h0000_F000;
    in_shamt = 5'd3;
    in_arith = 1'b0;
    @(posedge clk);
    tick();
    in_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (ovld == 2'b11) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_reach_hold", 0, 32'(ok), 32'd1);
    in_valid = 1'b1;
    in_data  = 32'hAAAA_0000;
    in_shamt = 5'd1;
    in_arith = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      check("bp_in_ready",  0, 32'(rdy),  32'd0);
      check("bp_out_valid", 0, 32'(ovld), 32'd3);
      check("bp_out_data",  0, odat[0],   32'h0000_1E00);
      check("bp_out_data",  1, odat[1],   32'h0000_1E00);
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_after_take", 0, 32'(rdy), 32'd3);
    tick();
    in_valid = 1'b0;
    check("bp_pending_accepted", 0, 32'(bsy), 32'd3);
    ok = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (ovld[0]) begin
        ok = 1'b1;
        check("bp_pending_result", 0, odat[0], 32'hD555_0000);
        break;
      end
      tick();
    end
    check("bp_pending_done", 0, 32'(ok), 32'd1);

    // Reset in the middle of a 20-bit shift discards the operation at once.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    in_valid = 1'b1;
    in_data  = 32'hFFFF_0000;
    in_shamt = 5'd20;
    in_arith = 1'b1;
    @(posedge clk);
    tick();
    in_valid = 1'b0;
    @(posedge clk);
    check("mid_shift_busy", 0, 32'(bsy), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 0, 32'(ovld), 32'd0);
    check("rst_out_data",  0, odat[0],   32'h0);
    check("rst_out_data",  1, odat[1],   32'h0);
    check("rst_busy",      0, 32'(bsy),  32'd0);
    check("rst_in_ready",  0, 32'(rdy),  32'd3);
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;
    run_op(32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 8, 32'h0000_0001, 2);

    // Randomized traffic with random backpressure, checked against the model every cycle.
    for (int n = 0; n < 1500; n++) begin
      tick();
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_shamt  = 5'($urandom_range(0, 31));
      in_arith  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
